// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, functs,
// ALU codes, mux select codes, FSM states and the per-state control word.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       ior_d;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] aluop;
        logic [1:0] pc_src;
        logic       instr_done;
    } ctrl_t;

    // Control word for a state; funct_ok only matters for the R-type write-back.
    function automatic ctrl_t state_ctrl(input state_e s, input logic funct_ok);
        ctrl_t c;
        c = '0;
        c.alu_src_b = SRCB_REG;
        c.aluop     = ALUOP_ADD;
        c.pc_src    = PCSRC_ALU;
        case (s)
            S_FETCH: begin
                c.ir_write  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.pc_write  = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_b = SRCB_IMM_SH;
            end
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                c.ior_d = 1'b1;
            end
            S_MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                c.ior_d      = 1'b1;
                c.mem_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.aluop     = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.reg_dst    = 1'b1;
                c.reg_write  = funct_ok;
                c.instr_done = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a  = 1'b1;
                c.aluop      = ALUOP_SUB;
                c.pc_src     = PCSRC_ALUOUT;
                c.branch     = 1'b1;
                c.instr_done = 1'b1;
            end
            S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: begin
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_JUMP: begin
                c.pc_src     = PCSRC_JUMP;
                c.pc_write   = 1'b1;
                c.instr_done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// ALU control decode: fixed add/sub for address and branch work, funct-driven
// for R-type; funct_ok flags whether funct is one of the supported operations.
module mips_alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       funct_ok
);

    logic [2:0] funct_code;

    always_comb begin
        funct_ok   = 1'b1;
        funct_code = ALU_ADD;
        case (funct)
            FN_ADD: funct_code = ALU_ADD;
            FN_SUB: funct_code = ALU_SUB;
            FN_AND: funct_code = ALU_AND;
            FN_OR:  funct_code = ALU_OR;
            FN_SLT: funct_code = ALU_SLT;
            default: begin
                funct_ok   = 1'b0;
                funct_code = ALU_ADD;
            end
        endcase
    end

    always_comb begin
        alu_control = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            default:   alu_control = funct_code;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute over 3-5 clocks
// and drives every datapath select and write strobe from registered state.
//
// state     | meaning
// FETCH     | read instr at PC into IR, PC <= PC+4
// DECODE    | compute branch target into ALUOut, dispatch on opcode
// MEMADR    | lw/sw effective address A + SignImm
// MEMREAD   | read data memory at ALUOut
// MEMWB     | write loaded data to rt
// MEMWRITE  | write B to memory at ALUOut
// EXECUTE   | R-type ALU op on A, B
// ALUWB     | write ALUOut to rd (suppressed for unknown funct)
// BRANCH    | compare A - B, load branch target when zero
// ADDIEX    | A + SignImm
// ADDIWB    | write ALUOut to rt
// JUMP      | load jump target into PC
module mips_mc_control
    import mips_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic       ior_d,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] pc_src,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    state_e state_q;
    state_e state_n;
    ctrl_t  ctrl_q;
    ctrl_t  ctrl_eff;
    logic   illegal_q;
    logic   funct_ok;
    logic   op_known;
    logic   set_illegal;

    always_comb begin
        state_n  = S_FETCH;
        op_known = 1'b1;
        case (state_q)
            S_FETCH: state_n = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_n = S_MEMADR;
                    OP_RTYPE:     state_n = S_EXECUTE;
                    OP_BEQ:       state_n = S_BRANCH;
                    OP_ADDI:      state_n = S_ADDIEX;
                    OP_J:         state_n = S_JUMP;
                    default: begin
                        state_n  = S_FETCH;
                        op_known = 1'b0;
                    end
                endcase
            end
            S_MEMADR:   state_n = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_n = S_MEMWB;
            S_EXECUTE:  state_n = S_ALUWB;
            S_ADDIEX:   state_n = S_ADDIWB;
            default:    state_n = S_FETCH;
        endcase
    end

    assign set_illegal = ((state_q == S_DECODE) && !op_known) ||
                         ((state_q == S_EXECUTE) && !funct_ok);

    // Control word is registered alongside the state it belongs to.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_FETCH;
            ctrl_q    <= state_ctrl(S_FETCH, 1'b1);
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_n;
            ctrl_q  <= state_ctrl(state_n, funct_ok);
            if (set_illegal) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // While reset is held, strobes are killed and selects show FETCH values.
    always_comb begin
        ctrl_eff = ctrl_q;
        if (reset) begin
            ctrl_eff            = state_ctrl(S_FETCH, 1'b1);
            ctrl_eff.pc_write   = 1'b0;
            ctrl_eff.ir_write   = 1'b0;
            ctrl_eff.reg_write  = 1'b0;
            ctrl_eff.mem_write  = 1'b0;
            ctrl_eff.instr_done = 1'b0;
            ctrl_eff.branch     = 1'b0;
        end
    end

    mips_alu_decoder u_alu_decoder (
        .aluop       (ctrl_eff.aluop),
        .funct       (funct),
        .alu_control (alu_control),
        .funct_ok    (funct_ok)
    );

    assign pc_en      = ctrl_eff.pc_write | (ctrl_eff.branch & zero);
    assign ior_d      = ctrl_eff.ior_d;
    assign mem_write  = ctrl_eff.mem_write;
    assign ir_write   = ctrl_eff.ir_write;
    assign reg_dst    = ctrl_eff.reg_dst;
    assign mem_to_reg = ctrl_eff.mem_to_reg;
    assign reg_write  = ctrl_eff.reg_write;
    assign alu_src_a  = ctrl_eff.alu_src_a;
    assign alu_src_b  = ctrl_eff.alu_src_b;
    assign pc_src     = ctrl_eff.pc_src;
    assign instr_done = ctrl_eff.instr_done;
    assign illegal    = illegal_q;
    assign state      = state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Self-checking bench for mips_mc_control: per-instruction state paths and
// per-state output values taken from the instruction-level behaviour.
module tb_mips_mc_control;

    typedef struct packed {
        logic       pc_en;
        logic       ior_d;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic [1:0] pc_src;
        logic       instr_done;
    } outs_t;

    logic       clock;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_en, ior_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, instr_done, illegal;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic [3:0] state;

    outs_t act;
    int    n_cmp = 0;
    int    n_bad = 0;
    logic  ill_m = 1'b0;
    logic [5:0] good_fn [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};

    mips_mc_control dut (
        .clock       (clock),
        .reset       (reset),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .pc_en       (pc_en),
        .ior_d       (ior_d),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_control (alu_control),
        .pc_src      (pc_src),
        .instr_done  (instr_done),
        .illegal     (illegal),
        .state       (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb act = {pc_en, ior_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                       alu_src_a, alu_src_b, alu_control, pc_src, instr_done};

    function automatic logic fn_valid(input logic [5:0] fn);
        return (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) || (fn == 6'h25) || (fn == 6'h2a);
    endfunction

    function automatic logic [2:0] fn_alu(input logic [5:0] fn);
        case (fn)
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h2a:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    // Expected outputs in a given state number, straight from the state listing.
    function automatic outs_t model_out(input int st, input logic z, input logic [5:0] fn);
        outs_t o;
        o = '0;
        o.alu_control = 3'b010;
        case (st)
            0:  begin o.ir_write = 1; o.alu_src_b = 2'b01; o.pc_en = 1; end
            1:  o.alu_src_b = 2'b11;
            2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            3:  o.ior_d = 1;
            4:  begin o.mem_to_reg = 1; o.reg_write = 1; o.instr_done = 1; end
            5:  begin o.ior_d = 1; o.mem_write = 1; o.instr_done = 1; end
            6:  begin o.alu_src_a = 1; o.alu_control = fn_alu(fn); end
            7:  begin o.reg_dst = 1; o.reg_write = fn_valid(fn); o.instr_done = 1; end
            8:  begin o.alu_src_a = 1; o.alu_control = 3'b110; o.pc_src = 2'b01;
                      o.pc_en = z; o.instr_done = 1; end
            9:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            10: begin o.reg_write = 1; o.instr_done = 1; end
            11: begin o.pc_src = 2'b10; o.pc_en = 1; o.instr_done = 1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    // Run one instruction from its FETCH cycle; zmode 0/1 fixes zero, 2 randomizes it.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode);
        int    path[$];
        outs_t exp_o;
        path.push_back(0);
        path.push_back(1);
        case (op)
            6'b100011: begin path.push_back(2); path.push_back(3); path.push_back(4); end
            6'b101011: begin path.push_back(2); path.push_back(5); end
            6'b000000: begin path.push_back(6); path.push_back(7); end
            6'b000100: path.push_back(8);
            6'b001000: begin path.push_back(9); path.push_back(10); end
            6'b000010: path.push_back(11);
            default: ;
        endcase
        opcode = op;
        funct  = fn;
        for (int k = 0; k < path.size(); k++) begin
            zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
            #1;
            if (path[k] == 7 && !fn_valid(fn)) ill_m = 1'b1;
            exp_o = model_out(path[k], zero, fn);
            n_cmp++;
            if (state !== 4'(path[k])) begin
                n_bad++;
                $display("FAIL state op=%b step=%0d got=%0d want=%0d", op, k, state, path[k]);
            end
            n_cmp++;
            if (act !== exp_o) begin
                n_bad++;
                $display("FAIL outputs op=%b fn=%b st=%0d z=%b got=%h want=%h",
                         op, fn, path[k], zero, act, exp_o);
            end
            n_cmp++;
            if (illegal !== ill_m) begin
                n_bad++;
                $display("FAIL illegal op=%b fn=%b st=%0d got=%b want=%b", op, fn, path[k], illegal, ill_m);
            end
            if (path[k] == 1 && path.size() == 2) ill_m = 1'b1;
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset;
        outs_t rst_o;
        rst_o = '0;
        rst_o.alu_src_b   = 2'b01;
        rst_o.alu_control = 3'b010;
        repeat (3) begin
            @(posedge clock);
            #1;
            opcode = 6'($urandom);
            funct  = 6'($urandom);
            zero   = 1'($urandom_range(0, 1));
            #1;
            n_cmp++;
            if (act !== rst_o) begin
                n_bad++;
                $display("FAIL reset_outputs got=%h want=%h", act, rst_o);
            end
            n_cmp++;
            if (state !== 4'd0 || illegal !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_state got state=%0d illegal=%b want 0/0", state, illegal);
            end
        end
        reset = 1'b0;
        ill_m = 1'b0;
        #1;
        n_cmp++;
        if (act !== model_out(0, zero, funct) || state !== 4'd0) begin
            n_bad++;
            $display("FAIL first_fetch got=%h state=%0d want=%h state=0", act, state, model_out(0, zero, funct));
        end
    endtask

    task automatic test_lw;     run_instr(6'b100011, 6'($urandom), 2); endtask
    task automatic test_sw;     run_instr(6'b101011, 6'($urandom), 2); endtask
    task automatic test_beq;
        run_instr(6'b000100, 6'($urandom), 1);
        run_instr(6'b000100, 6'($urandom), 0);
    endtask
    task automatic test_addi_j;
        run_instr(6'b001000, 6'($urandom), 2);
        run_instr(6'b000010, 6'($urandom), 2);
    endtask
    task automatic test_rtype;
        run_instr(6'b000000, 6'b101010, 2);
        run_instr(6'b000000, 6'b100010, 2);
    endtask

    task automatic test_random;
        logic [5:0] op, fn;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 7))
                0: op = 6'b100011;
                1: op = 6'b101011;
                2, 6: op = 6'b000000;
                3: op = 6'b000100;
                4: op = 6'b001000;
                5: op = 6'b000010;
                default: op = 6'($urandom);
            endcase
            if ($urandom_range(0, 4) != 0) fn = good_fn[$urandom_range(0, 4)];
            else fn = 6'($urandom);
            run_instr(op, fn, 2);
        end
    endtask

    task automatic test_illegal;
        run_instr(6'b000000, 6'b000111, 2);
        run_instr(6'b100011, 6'($urandom), 2);
        run_instr(6'b111111, 6'($urandom), 2);
        run_instr(6'b000010, 6'($urandom), 2);
    endtask

    task automatic test_reset_mid;
        opcode = 6'b100011;
        funct  = 6'($urandom);
        zero   = 1'b0;
        repeat (3) begin @(posedge clock); #1; end
        n_cmp++;
        if (state !== 4'd3) begin
            n_bad++;
            $display("FAIL mid_memread got state=%0d want=3", state);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({pc_en, ir_write, reg_write, mem_write, instr_done} !== 5'b0) begin
            n_bad++;
            $display("FAIL mid_reset_strobes got=%b want=00000",
                     {pc_en, ir_write, reg_write, mem_write, instr_done});
        end
        @(posedge clock);
        #1;
        ill_m = 1'b0;
        n_cmp++;
        if (state !== 4'd0 || reg_write !== 1'b0 || illegal !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_after got state=%0d reg_write=%b illegal=%b want 0/0/0",
                     state, reg_write, illegal);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (state !== 4'd0 || ir_write !== 1'b1 || pc_en !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_reset_refetch got state=%0d ir_write=%b pc_en=%b want 0/1/1",
                     state, ir_write, pc_en);
        end
        run_instr(6'b101011, 6'($urandom), 2);
    endtask

    initial begin
        reset  = 1'b1;
        opcode = 6'b0;
        funct  = 6'b0;
        zero   = 1'b0;
        test_reset();
        test_lw();
        test_sw();
        test_beq();
        test_addi_j();
        test_rtype();
        test_random();
        test_illegal();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
